branch_outcome_predictor: RTL and testbench

Branch-history table that consumes the ALU's `zero` flag at the EX stage to resolve conditional branches and trains a table of 2-bit saturating counters indexed by PC. It supplies a taken/not-taken prediction to the fetch stage each cycle. It flags mispredictions back to the pipeline for flush and keeps running branch and mispredict statistics.

---
 rtl/branch_outcome_predictor.sv | 89 ++++++++
 tb/tb_branch_outcome_predictor.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/branch_outcome_predictor.sv
// Branch predictor with a PC-indexed table of 2-bit saturating counters.
// Resolves BEQ/BNE from the ALU zero flag, trains the table and counts branches and mispredicts.
module branch_outcome_predictor #(
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned PC_WIDTH   = 64,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PC_WIDTH-1:0]  if_pc,
  output logic                 if_predict_taken,
  input  logic                 ex_valid,
  input  logic [1:0]           ex_branch_type,
  input  logic [PC_WIDTH-1:0]  ex_pc,
  input  logic                 ex_zero,
  input  logic                 ex_predicted_taken,
  output logic                 ex_taken,
  output logic                 ex_mispredict,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  localparam int unsigned ENTRIES     = 2 ** INDEX_BITS;
  localparam logic [1:0]  BR_BEQ      = 2'b01;
  localparam logic [1:0]  BR_BNE      = 2'b10;
  localparam logic [1:0]  CNT_WEAK_NT = 2'b01;
  localparam logic [1:0]  CNT_MAX     = 2'b11;
  localparam logic [1:0]  CNT_MIN     = 2'b00;

  logic [ENTRIES-1:0][1:0] table_q, table_d;
  logic [CNT_WIDTH-1:0]    branch_count_q, branch_count_d;
  logic [CNT_WIDTH-1:0]    mispredict_count_q, mispredict_count_d;
  logic [INDEX_BITS-1:0]   if_idx, ex_idx;
  logic [1:0]              ex_cnt;
  logic                    ex_is_branch;

  assign if_idx = if_pc[INDEX_BITS+1:2];
  assign ex_idx = ex_pc[INDEX_BITS+1:2];

  // Word-offset and high PC bits are dropped from the index; aliasing is intended.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], if_pc[PC_WIDTH-1:INDEX_BITS+2],
                            ex_pc[1:0], ex_pc[PC_WIDTH-1:INDEX_BITS+2]};

  // Resolve the EX-stage branch outcome and misprediction.
  always_comb begin
    ex_taken     = 1'b0;
    ex_is_branch = ex_valid & ((ex_branch_type == BR_BEQ) | (ex_branch_type == BR_BNE));
    case (ex_branch_type)
      BR_BEQ:  ex_taken = ex_zero;
      BR_BNE:  ex_taken = ~ex_zero;
      default: ex_taken = 1'b0;
    endcase
    ex_mispredict = ex_is_branch & (ex_taken != ex_predicted_taken);
  end

  // Saturating counter training and statistics.
  always_comb begin
    table_d            = table_q;
    ex_cnt             = table_q[ex_idx];
    branch_count_d     = branch_count_q + CNT_WIDTH'(ex_is_branch);
    mispredict_count_d = mispredict_count_q + CNT_WIDTH'(ex_mispredict);
    if (ex_is_branch) begin
      if (ex_taken && (ex_cnt != CNT_MAX)) begin
        table_d[ex_idx] = ex_cnt + 2'd1;
      end else if (!ex_taken && (ex_cnt != CNT_MIN)) begin
        table_d[ex_idx] = ex_cnt - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      table_q            <= {ENTRIES{CNT_WEAK_NT}};
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      table_q            <= table_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  // Lookup reads registered state only, so a same-cycle update is not bypassed.
  assign if_predict_taken = table_q[if_idx][1];
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_outcome_predictor.sv
// Bench for branch_outcome_predictor: directed vector table, wrap check on a 4-bit-counter
// instance, then randomized traffic against an array-based reference model.
module tb_branch_outcome_predictor;

  logic        clk;
  logic        reset;
  logic [63:0] if_pc;
  logic        ex_valid;
  logic [1:0]  ex_branch_type;
  logic [63:0] ex_pc;
  logic        ex_zero;
  logic        ex_predicted_taken;
  logic        if_predict_taken, ex_taken, ex_mispredict;
  logic [31:0] branch_count, mispredict_count;
  logic        if_predict_taken4, ex_taken4, ex_mispredict4;
  logic [3:0]  branch_count4, mispredict_count4;

  branch_outcome_predictor dut (
    .clk(clk), .reset(reset), .if_pc(if_pc), .if_predict_taken(if_predict_taken),
    .ex_valid(ex_valid), .ex_branch_type(ex_branch_type), .ex_pc(ex_pc), .ex_zero(ex_zero),
    .ex_predicted_taken(ex_predicted_taken), .ex_taken(ex_taken), .ex_mispredict(ex_mispredict),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  branch_outcome_predictor #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .if_pc(if_pc), .if_predict_taken(if_predict_taken4),
    .ex_valid(ex_valid), .ex_branch_type(ex_branch_type), .ex_pc(ex_pc), .ex_zero(ex_zero),
    .ex_predicted_taken(ex_predicted_taken), .ex_taken(ex_taken4), .ex_mispredict(ex_mispredict4),
    .branch_count(branch_count4), .mispredict_count(mispredict_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [63:0] ipc;
    logic        v;
    logic [1:0]  ty;
    logic [63:0] epc;
    logic        z;
    logic        p;
    int          e_pred;  // -1 means not checked
    int          e_tkn;
    int          e_mis;
    int          e_bc;
    int          e_mc;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: one small integer 0..3 per table entry, plain counts.
  int          m_ctr[16];
  int unsigned m_bc, m_mc;

  function automatic int m_taken(logic [1:0] ty, logic z);
    if (ty == 2'd1) return int'(z);
    if (ty == 2'd2) return int'(!z);
    return 0;
  endfunction

  function automatic int m_is_br(logic v, logic [1:0] ty);
    return int'(v && (ty == 2'd1 || ty == 2'd2));
  endfunction

  function automatic int m_idx(logic [63:0] pc);
    return int'((pc / 64'd4) % 64'd16);
  endfunction

  task automatic model_edge();
    int i, t;
    if (reset) begin
      for (int k = 0; k < 16; k++) m_ctr[k] = 1;
      m_bc = 0;
      m_mc = 0;
    end else if (m_is_br(ex_valid, ex_branch_type) != 0) begin
      i = m_idx(ex_pc);
      t = m_taken(ex_branch_type, ex_zero);
      m_bc++;
      if (t != int'(ex_predicted_taken)) m_mc++;
      if (t != 0) m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
      else        m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [63:0] ip, input logic v, input logic [1:0] ty,
                       input logic [63:0] ep, input logic z, input logic p);
    reset = r; if_pc = ip; ex_valid = v; ex_branch_type = ty;
    ex_pc = ep; ex_zero = z; ex_predicted_taken = p;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic vec_t mk(logic r, logic [63:0] ip, logic v, logic [1:0] ty, logic [63:0] ep,
                              logic z, logic p, int epr, int etk, int emi, int ebc, int emc);
    vec_t x;
    x.rst = r; x.ipc = ip; x.v = v; x.ty = ty; x.epc = ep; x.z = z; x.p = p;
    x.e_pred = epr; x.e_tkn = etk; x.e_mis = emi; x.e_bc = ebc; x.e_mc = emc;
    return x;
  endfunction

  initial begin
    // Lookup sweep right after reset.
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk(0, 64'(i * 4), 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Saturation up at 0x10, prediction held 0.
    vecs.push_back(mk(0, 64'h10, 1, 2'd1, 64'h10, 1, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 64'h10, 1, 2'd1, 64'h10, 1, 0, 1, 1, 1, 1, 1));
    vecs.push_back(mk(0, 64'h10, 1, 2'd1, 64'h10, 1, 0, 1, 1, 1, 2, 2));
    vecs.push_back(mk(0, 64'h10, 0, 2'd0, 0, 0, 0, 1, 0, 0, 3, 3));
    // BNE not taken at 0x24 down to 00, then one taken BNE leaves it weak-NT.
    vecs.push_back(mk(0, 64'h24, 1, 2'd2, 64'h24, 1, 1, 0, 0, 1, 3, 3));
    vecs.push_back(mk(0, 64'h24, 1, 2'd2, 64'h24, 1, 0, 0, 0, 0, 4, 4));
    vecs.push_back(mk(0, 64'h24, 1, 2'd2, 64'h24, 0, 0, 0, 1, 1, 5, 4));
    vecs.push_back(mk(0, 64'h24, 0, 2'd0, 0, 0, 0, 0, 0, 0, 6, 5));
    // Filtering: bubble, type none, reserved type, all with zero=1.
    vecs.push_back(mk(0, 64'h24, 0, 2'd1, 64'h24, 1, 1, 0, -1, 0, 6, 5));
    vecs.push_back(mk(0, 64'h24, 1, 2'd0, 64'h24, 1, 1, 0, 0, 0, 6, 5));
    vecs.push_back(mk(0, 64'h24, 1, 2'd3, 64'h24, 1, 1, 0, 0, 0, 6, 5));
    vecs.push_back(mk(0, 64'h24, 0, 2'd0, 0, 0, 0, 0, 0, 0, 6, 5));
    // Aliasing 0x48 onto 0x08, same-cycle read sees the old value.
    vecs.push_back(mk(0, 64'h48, 1, 2'd1, 64'h08, 1, 0, 0, 1, 1, 6, 5));
    vecs.push_back(mk(0, 64'h48, 0, 2'd0, 0, 0, 0, 1, 0, 0, 7, 6));
    // Reset with a concurrent taken BEQ on the strong-T entry.
    vecs.push_back(mk(1, 64'h10, 1, 2'd1, 64'h10, 1, 0, 1, 1, 1, 7, 6));
    vecs.push_back(mk(0, 64'h10, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 64'h08, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0));

    drive(1, 0, 0, 2'd0, 0, 0, 0);
    @(posedge clk); #1;
    drive(1, 0, 0, 2'd0, 0, 0, 0);
    tick();

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ipc, vecs[i].v, vecs[i].ty, vecs[i].epc, vecs[i].z, vecs[i].p);
      if (vecs[i].e_pred >= 0) chk($sformatf("vec%0d pred", i), 64'(if_predict_taken), 64'(vecs[i].e_pred));
      if (vecs[i].e_tkn >= 0)  chk($sformatf("vec%0d taken", i), 64'(ex_taken), 64'(vecs[i].e_tkn));
      chk($sformatf("vec%0d mispredict", i), 64'(ex_mispredict), 64'(vecs[i].e_mis));
      chk($sformatf("vec%0d branch_count", i), 64'(branch_count), 64'(vecs[i].e_bc));
      chk($sformatf("vec%0d mispredict_count", i), 64'(mispredict_count), 64'(vecs[i].e_mc));
      chk($sformatf("vec%0d branch_count4", i), 64'(branch_count4), 64'(vecs[i].e_bc % 16));
      tick();
    end

    // Counter wrap: 17 correctly predicted not-taken branches from a zero count.
    for (int i = 0; i < 17; i++) begin
      drive(0, 64'h30, 1, 2'd1, 64'h30, 0, 0);
      tick();
    end
    drive(0, 64'h30, 0, 2'd0, 0, 0, 0);
    chk("wrap branch_count", 64'(branch_count), 64'd17);
    chk("wrap branch_count4", 64'(branch_count4), 64'd1);
    chk("wrap mispredict_count4", 64'(mispredict_count4), 64'd0);
    chk("wrap pred 0x30", 64'(if_predict_taken), 64'd0);
    tick();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      logic [63:0] ip, ep;
      logic [1:0]  ty;
      ip = {$urandom, $urandom};
      ep = {$urandom, $urandom};
      ty = 2'($urandom_range(0, 3));
      drive(($urandom_range(0, 59) == 0), ip, ($urandom_range(0, 3) != 0), ty, ep,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      chk("rnd pred", 64'(if_predict_taken), 64'(m_ctr[m_idx(if_pc)] >= 2));
      chk("rnd taken", 64'(ex_taken), 64'(m_taken(ex_branch_type, ex_zero)));
      chk("rnd mispredict", 64'(ex_mispredict),
          64'(m_is_br(ex_valid, ex_branch_type) != 0 &&
              m_taken(ex_branch_type, ex_zero) != int'(ex_predicted_taken)));
      chk("rnd branch_count", 64'(branch_count), 64'(m_bc));
      chk("rnd mispredict_count", 64'(mispredict_count), 64'(m_mc));
      chk("rnd branch_count4", 64'(branch_count4), 64'(m_bc % 16));
      chk("rnd mispredict_count4", 64'(mispredict_count4), 64'(m_mc % 16));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
